tpu_host_driver: RTL and testbench

Host-side initiator for the 2x2 TPU pin protocol. It accepts one matrix-multiply job (four 8-bit weights and four 8-bit inputs) on a valid/ready port and sequences it onto the TPU's `ui_in`/`uio_in` pins: load, start, wait for `done`, read back. It then returns the four 16-bit accumulations as one result beat. It sits in the FPGA/SoC harness facing the TPU pins, and serves as the bench's reference bus master.

---
 rtl/tpu_host_driver.sv | 83 ++++++++
 tb/tb_tpu_host_driver.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_host_driver.sv
// tpu_host_driver: sequences one 2x2 matmul job onto the TPU pins and returns the four accumulations
module tpu_host_driver #(
  parameter int READ_LAT = 1,
  parameter int TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [31:0] job_w,
  input  logic [31:0] job_x,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] res_c,
  output logic        res_err,
  output logic [7:0]  tpu_ui_in,
  output logic [7:0]  tpu_uio_in,
  input  logic [7:0]  tpu_uo_out,
  input  logic [7:0]  tpu_uio_out
);
  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, START, WAIT_DONE, READ, RESP} state_t;
  localparam logic [15:0] READ_END = 16'(7 + READ_LAT);
  state_t state, state_d;
  logic [15:0] cnt, cnt_d, cap_idx;
  logic [63:0] job;
  logic [7:0] ui_d;
  logic [2:0] op_d;
  logic done, timeout_hit, capture, unused_ok;
  assign done = tpu_uio_out[7];
  assign timeout_hit = ({1'b0, cnt} + 17'd1) == 17'(TIMEOUT);
  assign cap_idx = cnt - 16'(READ_LAT);
  assign capture = state == READ && cnt >= 16'(READ_LAT);
  assign job_ready = state == IDLE;
  assign res_valid = state == RESP;
  assign unused_ok = &{1'b0, tpu_uio_out[6:0], cap_idx[15:3]};
  // State, phase counter, latched job, pin registers and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      job <= '0;
      res_c <= '0;
      res_err <= 1'b0;
      tpu_ui_in <= '0;
      tpu_uio_in <= '0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      tpu_ui_in <= ui_d;
      tpu_uio_in <= {5'b0, op_d};
      if (state == IDLE && job_valid) begin
        job <= {job_x, job_w};
        res_c <= '0;
        res_err <= 1'b0;
      end
      if (state == WAIT_DONE && !done && timeout_hit) res_err <= 1'b1;
      if (capture) res_c[{cap_idx[2:0], 3'b000} +: 8] <= tpu_uo_out;
    end
  end
  // Next state; the phase counter restarts on every state change
  always_comb begin
    state_d = state;
    case (state)
      IDLE:      state_d = job_valid ? CLEAR : IDLE;
      CLEAR:     state_d = LOAD;
      LOAD:      state_d = (cnt == 16'd7) ? START : LOAD;
      START:     state_d = WAIT_DONE;
      WAIT_DONE: state_d = done ? READ : (timeout_hit ? RESP : WAIT_DONE);
      READ:      state_d = (cnt == READ_END) ? RESP : READ;
      RESP:      state_d = res_ready ? IDLE : RESP;
      default:   state_d = IDLE;
    endcase
    cnt_d = (state_d != state) ? '0 : cnt + 16'd1;
  end
  // Pin values derived from the next state so the registered pins line up with the state
  always_comb begin
    op_d = (state_d == CLEAR) ? 3'b100 :
           (state_d == LOAD) ? 3'b001 :
           (state_d == START) ? 3'b010 :
           (state_d == READ && cnt_d < 16'd8) ? 3'b011 : 3'b000;
    ui_d = (state_d == LOAD) ? job[{cnt_d[2:0], 3'b000} +: 8] : 8'h00;
  end
endmodule

// File: tb/tb_tpu_host_driver.sv
// tb_tpu_host_driver: random and directed jobs on two drivers (READ_LAT 1 and 3) against a TPU pin model
module tb_tpu_host_driver;
  localparam int TO = 10;
  logic clk = 0, rst_n = 1;
  logic job_valid[2], job_ready[2], res_valid[2], res_ready[2], res_err[2];
  logic [31:0] job_w[2], job_x[2];
  logic [63:0] res_c[2];
  logic [7:0] ui[2], uio[2], uo[2], uio_o[2];
  int done_dly[2];
  int checks = 0, failures = 0;
  bit busy[2], ee[2];
  int t[2], resp_t[2], rd0[2];
  logic [63:0] ec[2], eb[2], cb[2];
  logic [7:0] mem[2][8];
  logic [7:0] pipe[2][3];
  int addr[2], rp[2], dc[2];
  bit dn[2];

  always #5 clk = ~clk;

  genvar g;
  for (g = 0; g < 2; g++) begin : lane
    tpu_host_driver #(.READ_LAT(g == 0 ? 1 : 3), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .job_valid(job_valid[g]), .job_ready(job_ready[g]),
      .job_w(job_w[g]), .job_x(job_x[g]),
      .res_valid(res_valid[g]), .res_ready(res_ready[g]),
      .res_c(res_c[g]), .res_err(res_err[g]),
      .tpu_ui_in(ui[g]), .tpu_uio_in(uio[g]),
      .tpu_uo_out(uo[g]), .tpu_uio_out(uio_o[g])
    );
  end

  function automatic int rl(input int l);
    return (l == 0) ? 1 : 3;
  endfunction

  function automatic logic [63:0] mm(input logic [31:0] w, input logic [31:0] x);
    int wb[4], xb[4];
    logic [15:0] c0, c1, c2, c3;
    for (int i = 0; i < 4; i++) begin
      wb[i] = int'(w[8*i +: 8]);
      xb[i] = int'(x[8*i +: 8]);
    end
    c0 = 16'(wb[0] * xb[0] + wb[1] * xb[2]);
    c1 = 16'(wb[0] * xb[1] + wb[1] * xb[3]);
    c2 = 16'(wb[2] * xb[0] + wb[3] * xb[2]);
    c3 = 16'(wb[2] * xb[1] + wb[3] * xb[3]);
    return {c3, c2, c1, c0};
  endfunction

  task automatic chk(input string nm, input logic [71:0] a, input logic [71:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  // TPU pin model: address-incrementing memory, matmul on START, delayed done, READ_LAT-deep read pipe
  initial begin
    for (int l = 0; l < 2; l++) begin
      addr[l] = 0; rp[l] = 0; dc[l] = -1; dn[l] = 0; cb[l] = '0; uo[l] = 0; uio_o[l] = 0;
      for (int i = 0; i < 3; i++) pipe[l][i] = 0;
      for (int i = 0; i < 8; i++) mem[l][i] = 0;
    end
    forever begin
      @(posedge clk);
      for (int l = 0; l < 2; l++) begin
        logic [7:0] rb;
        rb = 8'($urandom);
        case (uio[l][2:0])
          3'b100: begin addr[l] = 0; rp[l] = 0; dc[l] = -1; dn[l] = 0; end
          3'b001: begin mem[l][addr[l] % 8] = ui[l]; addr[l]++; end
          3'b010: begin
            cb[l] = mm({mem[l][3], mem[l][2], mem[l][1], mem[l][0]}, {mem[l][7], mem[l][6], mem[l][5], mem[l][4]});
            dc[l] = done_dly[l];
          end
          3'b011: begin rb = cb[l][8*(rp[l] % 8) +: 8]; rp[l]++; end
          default: ;
        endcase
        pipe[l][2] = pipe[l][1];
        pipe[l][1] = pipe[l][0];
        pipe[l][0] = rb;
        if (dc[l] == 0) dn[l] = 1;
        if (dc[l] >= 0) dc[l]--;
        uo[l] <= pipe[l][rl(l) - 1];
        uio_o[l] <= {dn[l], 7'($urandom)};
      end
    end
  end

  // Job-level model: per accepted job, the cycle schedule (CLEAR, LOAD x8, START, WAIT D, READ, RESP)
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      busy[0] = 0;
      busy[1] = 0;
    end else for (int l = 0; l < 2; l++) begin
      if (!busy[l]) begin
        if (job_valid[l]) begin
          busy[l] = 1;
          t[l] = 0;
          eb[l] = {job_x[l], job_w[l]};
          if (done_dly[l] >= 0 && done_dly[l] < TO) begin
            ee[l] = 0;
            ec[l] = mm(job_w[l], job_x[l]);
            rd0[l] = 11 + done_dly[l];
            resp_t[l] = rd0[l] + 8 + rl(l);
          end else begin
            ee[l] = 1;
            ec[l] = '0;
            rd0[l] = -100;
            resp_t[l] = 10 + TO;
          end
        end
      end else if (t[l] == resp_t[l]) begin
        if (res_ready[l]) busy[l] = 0;
      end else t[l]++;
    end
  end

  // Every-cycle comparison of both drivers against the job-level model
  initial forever begin
    @(negedge clk);
    for (int l = 0; l < 2; l++) begin
      logic [2:0] eo;
      logic [7:0] eu;
      bit v;
      v = busy[l] && t[l] == resp_t[l];
      eo = 0;
      eu = 0;
      if (busy[l] && !v) begin
        if (t[l] == 0) eo = 3'b100;
        else if (t[l] <= 8) begin eo = 3'b001; eu = eb[l][8*(t[l]-1) +: 8]; end
        else if (t[l] == 9) eo = 3'b010;
        else if (t[l] >= rd0[l] && t[l] < rd0[l] + 8) eo = 3'b011;
      end
      chk($sformatf("handshake%0d", l), 72'({job_ready[l], res_valid[l]}), 72'({!busy[l], v}));
      chk($sformatf("pins%0d", l), 72'({uio[l], ui[l]}), 72'({5'b0, eo, eu}));
      if (v) chk($sformatf("result%0d", l), 72'({res_err[l], res_c[l]}), 72'({ee[l], ec[l]}));
    end
  end

  task automatic run_job(input int l, input logic [31:0] w, input logic [31:0] x, input int dly,
                         input int hold, input bit keep, input logic [63:0] c, input bit err, input int lat);
    int n = 0;
    bit got = 0;
    job_w[l] = w; job_x[l] = x; done_dly[l] = dly; job_valid[l] = 1; res_ready[l] = 0;
    @(negedge clk);
    chk($sformatf("ready_before_accept%0d", l), 72'(job_ready[l]), 72'(1));
    @(posedge clk);
    #1;
    if (!keep) job_valid[l] = 0;
    job_w[l] = $urandom;
    job_x[l] = $urandom;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (res_valid[l]) got = 1;
      else n++;
    end
    chk("result_wait", 72'(got), 72'(1));
    chk("latency", 72'(n), 72'(lat));
    chk("res_c", 72'(res_c[l]), 72'(c));
    chk("res_err", 72'(res_err[l]), 72'(err));
    repeat (hold) @(negedge clk);
    res_ready[l] = 1;
    @(posedge clk);
    #1 res_ready[l] = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int l = 0; l < 2; l++) begin
      job_valid[l] = 0; res_ready[l] = 0; job_w[l] = 0; job_x[l] = 0; done_dly[l] = -1;
    end
    #3 rst_n = 0;
    #1;
    chk("reset_flags", 72'({job_ready[0], res_valid[0], res_err[0]}), 72'(3'b100));
    chk("reset_res_c", 72'(res_c[0]), 72'(0));
    chk("reset_pins", 72'({uio[0], ui[0]}), 72'(0));
    @(posedge clk);
    #1 rst_n = 1;
    run_job(0, 32'h04030201, 32'h08070605, 8, 0, 0, 64'h0032_002B_0016_0013, 0, 28);
    run_job(0, 32'h00FF00FF, 32'hFFFFFFFF, 2, 0, 0, 64'hFE01_FE01_FE01_FE01, 0, 22);
    run_job(0, $urandom, $urandom, -1, 0, 0, 64'h0, 1, 20);
    run_job(0, 32'h04030201, 32'h08070605, 9, 0, 0, 64'h0032_002B_0016_0013, 0, 29);
    run_job(1, 32'h00FF00FF, 32'hFFFFFFFF, 4, 20, 1, 64'hFE01_FE01_FE01_FE01, 0, 26);
    run_job(1, 32'h04030201, 32'h08070605, 0, 0, 0, 64'h0032_002B_0016_0013, 0, 22);
    repeat (3000) begin
      @(posedge clk);
      #1;
      for (int l = 0; l < 2; l++) begin
        if (!busy[l]) begin
          job_valid[l] = ($urandom % 3) != 0;
          done_dly[l] = (($urandom % 5) == 0) ? -1 : int'($urandom_range(0, 12));
        end else job_valid[l] = ($urandom % 2) != 0;
        job_w[l] = $urandom;
        job_x[l] = $urandom;
        res_ready[l] = ($urandom % 3) != 0;
      end
    end
    @(posedge clk);
    #1;
    for (int l = 0; l < 2; l++) begin job_valid[l] = 0; res_ready[l] = 1; end
    for (int i = 0; i < 200 && (busy[0] || busy[1]); i++) @(posedge clk);
    chk("drain", 72'({job_ready[0], job_ready[1]}), 72'(2'b11));
    @(posedge clk);
    #1;
    res_ready[0] = 0; res_ready[1] = 0;
    job_w[0] = 32'h04030201; job_x[0] = 32'h08070605; done_dly[0] = 3; job_valid[0] = 1;
    @(posedge clk);
    #1 job_valid[0] = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("midload_reset_flags", 72'({job_ready[0], res_valid[0], res_err[0]}), 72'(3'b100));
    chk("midload_reset_res_c", 72'(res_c[0]), 72'(0));
    chk("midload_reset_pins", 72'({uio[0], ui[0]}), 72'(0));
    chk("midload_reset_res_c1", 72'(res_c[1]), 72'(0));
    @(posedge clk);
    #1 rst_n = 1;
    run_job(0, 32'h04030201, 32'h08070605, 8, 0, 0, 64'h0032_002B_0016_0013, 0, 28);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
